// File: rtl/npu_layer_sequencer_pkg.sv
// Shared definitions for the 3x3 layer-pass sequencer: FSM encoding,
// tap count and the configuration legality limits.
package npu_layer_sequencer_pkg;

  // state | meaning
  // IDLE  | waiting for start; outputs quiet, bound level 0
  // BIAS  | one-cycle bias-load strobe, step 0
  // RUN   | scanning (row, column, step); one beat per cycle unless held
  // DRAIN | PIPE_LAT cycles for the arithmetic pipe to empty
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BIAS  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  localparam int N_TAPS         = 9;
  // A 3x3 window reaches two rows/columns past the output pixel.
  localparam int TAP_SPAN       = 2;
  // Highest column address the feature-map memory accepts.
  localparam int COL_ADDR_LIMIT = 79;

  // True when the whole window stays inside the addressable memory.
  function automatic logic cfg_legal(input int rows, input int cols, input int height_b);
    return ((rows + TAP_SPAN) <= ((1 << height_b) - 1)) &&
           ((cols + TAP_SPAN) <= COL_ADDR_LIMIT);
  endfunction

endpackage

// File: rtl/npu_layer_sequencer_if.sv
// Control/configuration and memory/PE strobe bundle of the layer sequencer.
interface npu_layer_sequencer_if #(
  parameter int WIDTH_B  = 7,
  parameter int HEIGHT_B = 3
);
  import npu_layer_sequencer_pkg::*;

  logic                         start;
  logic [WIDTH_B-1:0]           cfg_cols;
  logic [HEIGHT_B-1:0]          cfg_rows;
  logic [2:0]                   cfg_steps;
  logic [2:0]                   cfg_bound;
  logic                         hold;

  logic [WIDTH_B*N_TAPS-1:0]    readi_wr;
  logic [HEIGHT_B*N_TAPS-1:0]   readi_hr;
  logic [N_TAPS-1:0]            en_read;
  logic                         en_bias;
  logic [2:0]                   stepr;
  logic [2:0]                   step_pr;
  logic                         en_pe;
  logic [2:0]                   bound_levelr;
  logic                         busy;
  logic                         done;
  logic                         cfg_err;

  modport master (
    output start, cfg_cols, cfg_rows, cfg_steps, cfg_bound, hold,
    input  readi_wr, readi_hr, en_read, en_bias, stepr, step_pr, en_pe,
           bound_levelr, busy, done, cfg_err
  );

  modport slave (
    input  start, cfg_cols, cfg_rows, cfg_steps, cfg_bound, hold,
    output readi_wr, readi_hr, en_read, en_bias, stepr, step_pr, en_pe,
           bound_levelr, busy, done, cfg_err
  );

endinterface

// File: rtl/npu_tap_addr_gen.sv
// Combinational 3x3 window address generator: tap k = 3i+j reads
// column c+j and row r+i; tap 0 sits in the most significant slice.
module npu_tap_addr_gen
  import npu_layer_sequencer_pkg::*;
#(
  parameter int WIDTH_B  = 7,
  parameter int HEIGHT_B = 3
) (
  input  logic [HEIGHT_B-1:0]         r_i,
  input  logic [WIDTH_B-1:0]          c_i,
  output logic [WIDTH_B*N_TAPS-1:0]   wr_o,
  output logic [HEIGHT_B*N_TAPS-1:0]  hr_o
);

  // Offsets never wrap: the start check keeps c+2 and r+2 in range.
  always_comb begin
    wr_o = '0;
    hr_o = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      wr_o[(N_TAPS-1-k)*WIDTH_B +: WIDTH_B]   = c_i + WIDTH_B'(k % 3);
      hr_o[(N_TAPS-1-k)*HEIGHT_B +: HEIGHT_B] = r_i + HEIGHT_B'(k / 3);
    end
  end

endmodule

// File: rtl/npu_layer_sequencer.sv
// Sequencer for one 3x3 layer pass: bias load, (row, column, step) scan
// with back-pressure, pipeline drain and a completion pulse.
// All outputs are registers; start and hold only act through the FSM.
module npu_layer_sequencer
  import npu_layer_sequencer_pkg::*;
#(
  parameter int WIDTH_B  = 7,
  parameter int HEIGHT_B = 3,
  parameter int PIPE_LAT = 4
) (
  input logic                  clk,
  input logic                  reset,
  npu_layer_sequencer_if.slave bus
);

  localparam int                DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);

  seq_state_e                  state_q;
  logic [HEIGHT_B-1:0]         rows_q, r_q;
  logic [WIDTH_B-1:0]          cols_q, c_q;
  logic [2:0]                  steps_q, s_q, step_q, bound_q;
  logic                        scan_done_q;
  logic [DRAIN_W-1:0]          drain_q;
  logic [WIDTH_B*N_TAPS-1:0]   wr_q, tap_wr_d;
  logic [HEIGHT_B*N_TAPS-1:0]  hr_q, tap_hr_d;
  logic [N_TAPS-1:0]           en_read_q;
  logic                        en_bias_q, en_pe_q, busy_q, done_q, cfg_err_q;
  logic                        cfg_ok, last_beat;

  // s_q/c_q/r_q point at the next beat to issue, so the generator output
  // is exactly what gets registered when that beat goes out.
  npu_tap_addr_gen #(
    .WIDTH_B  (WIDTH_B),
    .HEIGHT_B (HEIGHT_B)
  ) u_tap_addr_gen (
    .r_i  (r_q),
    .c_i  (c_q),
    .wr_o (tap_wr_d),
    .hr_o (tap_hr_d)
  );

  assign cfg_ok    = cfg_legal(int'(bus.cfg_rows), int'(bus.cfg_cols), HEIGHT_B);
  assign last_beat = (s_q == steps_q) && (c_q == cols_q) && (r_q == rows_q);

  // Pass FSM with scan counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      steps_q     <= '0;
      r_q         <= '0;
      c_q         <= '0;
      s_q         <= '0;
      step_q      <= '0;
      bound_q     <= '0;
      scan_done_q <= 1'b0;
      drain_q     <= '0;
      wr_q        <= '0;
      hr_q        <= '0;
      en_read_q   <= '0;
      en_bias_q   <= 1'b0;
      en_pe_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      en_bias_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              state_q     <= BIAS;
              busy_q      <= 1'b1;
              en_bias_q   <= 1'b1;
              step_q      <= '0;
              rows_q      <= bus.cfg_rows;
              cols_q      <= bus.cfg_cols;
              steps_q     <= bus.cfg_steps;
              bound_q     <= bus.cfg_bound;
              r_q         <= '0;
              c_q         <= '0;
              s_q         <= '0;
              scan_done_q <= 1'b0;
            end else begin
              // Rejected: only the error strobe moves.
              cfg_err_q <= 1'b1;
            end
          end
        end
        BIAS, RUN: begin
          state_q <= RUN;
          if (scan_done_q) begin
            state_q   <= DRAIN;
            en_pe_q   <= 1'b0;
            en_read_q <= '0;
            drain_q   <= DRAIN_LOAD;
          end else if (bus.hold) begin
            // Counters and addresses stay put; the beat is reissued later.
            en_pe_q   <= 1'b0;
            en_read_q <= '0;
          end else begin
            en_pe_q   <= 1'b1;
            en_read_q <= {N_TAPS{1'b1}};
            step_q    <= s_q;
            wr_q      <= tap_wr_d;
            hr_q      <= tap_hr_d;
            if (last_beat) begin
              s_q         <= '0;
              c_q         <= '0;
              r_q         <= '0;
              scan_done_q <= 1'b1;
            end else if (s_q != steps_q) begin
              s_q <= s_q + 3'd1;
            end else begin
              s_q <= '0;
              if (c_q != cols_q) begin
                c_q <= c_q + WIDTH_B'(1);
              end else begin
                c_q <= '0;
                r_q <= r_q + HEIGHT_B'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - DRAIN_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          bound_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.readi_wr     = wr_q;
  assign bus.readi_hr     = hr_q;
  assign bus.en_read      = en_read_q;
  assign bus.en_bias      = en_bias_q;
  assign bus.stepr        = step_q;
  assign bus.step_pr      = step_q;
  assign bus.en_pe        = en_pe_q;
  assign bus.bound_levelr = bound_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cfg_err      = cfg_err_q;

endmodule

// File: doc/npu_layer_sequencer.md
NPU_LAYER_SEQUENCER -- requirements
Module: npu_layer_sequencer

Interface
REQ-001 Parameter WIDTH_B, default 7, meaning column-address width of the feature-map memory.
REQ-002 Parameter HEIGHT_B, default 3, meaning row-address width of the feature-map memory.
REQ-003 Parameter PIPE_LAT, default 4, meaning cycles from the last en_pe beat to the final out_en of the arithmetic part.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset is synchronous and active-low.
REQ-006 start  input  1  one-cycle request to run one 3x3 layer pass.
REQ-007 cfg_cols  input  WIDTH_B  output columns minus 1; sampled at accepted start.
REQ-008 cfg_rows  input  HEIGHT_B  output rows minus 1; sampled at accepted start.
REQ-009 cfg_steps  input  3  channel-group steps per pixel minus 1; sampled at accepted start.
REQ-010 cfg_bound  input  3  bound level for the arithmetic part; sampled at accepted start.
REQ-011 hold  input  1  back-pressure; freezes the scan while high.
REQ-012 readi_wr  output  WIDTH_B*9  nine tap column addresses, tap 0 in the MSB slice.
REQ-013 readi_hr  output  HEIGHT_B*9  nine tap row addresses, tap 0 in the MSB slice.
REQ-014 en_read  output  9  per-tap read enable.
REQ-015 en_bias  output  1  bias-load strobe.
REQ-016 stepr / step_pr  output  3 each  memory step and PE step; equal values.
REQ-017 en_pe  output  1  PE operand-valid.
REQ-018 bound_levelr  output  3  latched cfg_bound.
REQ-019 busy  output  1  high outside IDLE.
REQ-020 done  output  1  one-cycle completion pulse.
REQ-021 cfg_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-022 FSM states SHALL be IDLE, BIAS, RUN, DRAIN, DONE.
REQ-023 Start transition: IDLE with start=1 and legal configuration -> BIAS on the next cycle; cfg_* are latched on that edge.
REQ-024 Legal configuration: cfg_rows+2 <= 2**HEIGHT_B-1 and cfg_cols+2 <= 79.
REQ-025 Illegal start: cfg_err pulses one cycle, the FSM stays in IDLE, and no other output changes.
REQ-026 Start while busy=1 SHALL be ignored.
REQ-027 BIAS lasts exactly one cycle with en_bias=1 and step=0, then moves to RUN.
REQ-028 RUN: counters s (step), c (column), r (row) start at 0.
REQ-029 RUN nesting: s is innermost, then c, then r; each advances on every cycle with hold=0.
REQ-030 RUN outputs on each cycle with hold=0: en_pe=1, en_read=9'h1FF, stepr=step_pr=s.
REQ-031 Tap k=3i+j (i,j in 0..2) addresses: readi_wr = c+j, readi_hr = r+i.
REQ-032 Address widths: address sums SHALL NOT wrap; REQ-024 guarantees no overflow.
REQ-033 Hold: while hold=1 in RUN, en_pe=0, en_read=0, and all counters and addresses are frozen; operation resumes exactly where it stopped.
REQ-034 RUN exits to DRAIN after the beat where s=cfg_steps, c=cfg_cols and r=cfg_rows.
REQ-035 Beat count: exactly (cfg_rows+1)*(cfg_cols+1)*(cfg_steps+1) en_pe beats per pass.
REQ-036 DRAIN lasts PIPE_LAT cycles with en_pe=0 and is unaffected by hold.
REQ-037 DONE lasts one cycle with done=1, then returns to IDLE; start is accepted again in the following cycle.
REQ-038 bound_levelr holds the latched cfg_bound from BIAS through DONE, and 0 in IDLE.
REQ-039 Outputs SHALL be registered; no combinational path from start/hold to outputs other than via registered state.

Reset
REQ-040 While reset=0 at a clk edge, the FSM goes to IDLE; counters, addresses, en_read, en_bias, en_pe, stepr, step_pr, bound_levelr, busy, done and cfg_err all become 0.
REQ-041 Reset mid-pass SHALL abandon the pass with no done pulse.

Structure
REQ-042 A shared package SHALL hold the FSM state encoding, tap count 9, and the 79/row legality limits.
REQ-043 One sub-module, npu_tap_addr_gen, SHALL be combinational: (r,c) -> nine tap addresses, registered in the parent.

Verification
REQ-044 Single beat: cfg rows=0, cols=0, steps=0 -> en_bias at cycle 1; one en_pe beat at cycle 2 with taps (0..2,0..2); done at cycle 3+PIPE_LAT.
REQ-045 Full scan: rows=1, cols=2, steps=1 -> 12 beats; last beat c=2, r=1, s=1, tap 8 address (4,3).
REQ-046 Hold: rows=0, cols=1, steps=0; hold=1 for 3 cycles after the first beat -> en_pe low 3 cycles; second beat column 1; done delayed by 3.
REQ-047 Illegal start: cfg_rows=6 -> cfg_err pulse, busy stays 0; cfg_cols=78 behaves the same.
REQ-048 Start ignored while busy, and reset asserted mid-RUN -> all outputs 0 next cycle, no done; a new start is accepted afterwards.
